sfu_input_stage: RTL and testbench
==================================

// Module: sfu_input_stage
// PURPOSE
// - Parametrised, pipelined successor to the SFU operand selector.
// - For each accepted beat, per lane, picks the range-reduced operand (RRO) or the raw source operand, as set by the opcode.
// - Drives a registered, lane-masked operand vector into the SFU datapath with a valid/ready handshake.
// - Sits between the range-reduction unit and the SFU core; decouples SFU backpressure with a 2-entry skid buffer.
// PARAMETERS
// - LANES     4            number of parallel SIMD lanes
// - DATA_W    32           operand width per lane
// - OP_W      3            opcode width
// - RRO_MASK  8'b0001_0011 width 2**OP_W; bit k=1 -> opcode k selects RRO, else src (ops 0,1,4 -> RRO)
// PORTS
// - clk_i        in   1              clock, all logic rising-edge
// - rst_i        in   1              synchronous, active-high reset
// - flush_i      in   1              synchronous pipeline flush
// - in_valid_i   in   1              input beat valid
// - in_ready_o   out  1              stage can accept a beat
// - selop_i      in   OP_W           SFU opcode of the beat
// - lane_mask_i  in   LANES          per-lane active mask
// - rro_input_i  in   LANES*DATA_W   range-reduced operands, lane 0 in LSBs
// - src_i        in   LANES*DATA_W   raw source operands, lane 0 in LSBs
// - out_valid_o  out  1              output beat valid
// - out_ready_i  in   1              SFU core accepts beat
// - sfu_input_o  out  LANES*DATA_W   selected, masked operands
// - sfu_op_o     out  OP_W           opcode travelling with the beat
// - lane_mask_o  out  LANES          mask travelling with the beat
// - sel_rro_o    out  1              1 = beat carries RRO operands
// BEHAVIOUR
// - Reset (rst_i=1 at edge): both entries empty; out_valid_o=0, in_ready_o=1; all data outputs 0.
// - Accept: in_valid_i & in_ready_o. Deliver: out_valid_o & out_ready_i. Beats stay in order; no beat is dropped or duplicated.
// - Select: sel = RRO_MASK[selop_i], computed at accept and stored with the beat.
//   - Lane i output = lane_mask_i[i] ? (sel ? rro[i] : src[i]) : {DATA_W{1'b0}}.
// - Latency: 1 cycle. A beat accepted at edge N is on the outputs after edge N, when the output register is empty or drains at edge N.
// - Storage:
//   - Output register (head) plus skid register.
//   - in_ready_o is registered and equals !skid_full.
//   - Accept while the head is stalled (out_valid_o & !out_ready_i) -> beat goes to skid.
//   - Head drains while skid is full -> skid moves to the head, in_ready_o rises the next cycle.
// - Full (both entries held): in_ready_o=0; in_valid_i is ignored.
// - Empty: out_valid_o=0; outputs hold their last value (no X).
// - Simultaneous accept and deliver with one entry held: new beat replaces the head; occupancy stays 1.
// - Output data must not change while out_valid_o=1 and out_ready_i=0.
// - Flush: flush_i=1 at an edge empties both entries and discards any beat offered that cycle.
//   - Next cycle: out_valid_o=0, in_ready_o=1. rst_i takes priority over flush_i.
// - Reset mid-stream: all in-flight beats are lost; state as at reset.
// CONFIGURATION
// - SFU_IN_PERF_EN defined:
//   - Extra outputs rro_cnt_o[31:0] and src_cnt_o[31:0].
//   - One of them increments per delivered beat, by that beat's sel_rro_o.
//   - Wrap at 2**32; cleared by rst_i only (flush does not clear).
// - Undefined: ports and counters are absent; no other behaviour changes.
// TESTING
// - Reset: rst_i=1 for 2 cycles -> out_valid_o=0, in_ready_o=1, sfu_input_o=0.
// - Select: op=3'b001, mask=4'hF, rro lanes=32'hA0000000+i, src=32'h5+i, out_ready_i=1
//   -> next cycle sfu_input_o lanes=32'hA0000000+i, sel_rro_o=1.
//   Then op=3'b010 -> lanes=32'h5+i, sel_rro_o=0.
// - Masking: op=3'b100, mask=4'b0101 -> lanes 1,3 = 0; lanes 0,2 = RRO values.
// - Backpressure: out_ready_i=0, push beats A,B,C back-to-back
//   -> A,B held, in_ready_o=0 from cycle 2, C not accepted.
//   Then out_ready_i=1 -> A then B in order, in_ready_o=1 after A drains.
// - Flush: both entries full, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1; the offered beat is never output.
// - Perf (SFU_IN_PERF_EN): deliver 3 beats with ops {0,2,4} -> rro_cnt_o=2, src_cnt_o=1; flush leaves counts unchanged.

Source files
------------

// File: rtl/sfu_input_stage.sv
// SFU input stage: per-lane RRO/src operand select with lane masking, 2-entry skid.
// Define SFU_IN_PERF_EN to add delivered-beat counters rro_cnt_o/src_cnt_o.
module sfu_input_stage #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter logic [(2**OP_W)-1:0] RRO_MASK = 8'b0001_0011
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [OP_W-1:0]         selop_i,
  input  logic [LANES-1:0]        lane_mask_i,
  input  logic [LANES*DATA_W-1:0] rro_input_i,
  input  logic [LANES*DATA_W-1:0] src_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*DATA_W-1:0] sfu_input_o,
  output logic [OP_W-1:0]         sfu_op_o,
  output logic [LANES-1:0]        lane_mask_o,
`ifdef SFU_IN_PERF_EN
  output logic [31:0]             rro_cnt_o,
  output logic [31:0]             src_cnt_o,
`endif
  output logic                    sel_rro_o
);

  typedef struct packed {
    logic [LANES*DATA_W-1:0] data;
    logic [OP_W-1:0]         op;
    logic [LANES-1:0]        mask;
    logic                    sel;
  } beat_t;

  beat_t head_q, head_d;
  beat_t skid_q, skid_d;
  beat_t new_beat;
  logic  head_v_q, head_v_d;
  logic  skid_v_q, skid_v_d;
  logic  rdy_q, rdy_d;
  logic  accept, deliver;

  assign accept  = in_valid_i & rdy_q;
  assign deliver = head_v_q & out_ready_i;

  always_comb begin
    new_beat      = '0;
    new_beat.op   = selop_i;
    new_beat.mask = lane_mask_i;
    new_beat.sel  = RRO_MASK[selop_i];
    for (int i = 0; i < LANES; i++) begin
      if (lane_mask_i[i]) begin
        new_beat.data[i*DATA_W +: DATA_W] = new_beat.sel
          ? rro_input_i[i*DATA_W +: DATA_W]
          : src_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Head refills from skid first so beats stay in order.
  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush_i) begin
      head_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!head_v_q || out_ready_i) begin
      if (skid_v_q) begin
        head_d   = skid_q;
        head_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept) begin
        head_d   = new_beat;
        head_v_d = 1'b1;
      end else begin
        head_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = new_beat;
      skid_v_d = 1'b1;
    end
    rdy_d = !skid_v_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q   <= '0;
      skid_q   <= '0;
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      head_q   <= head_d;
      skid_q   <= skid_d;
      head_v_q <= head_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = head_v_q;
  assign sfu_input_o = head_q.data;
  assign sfu_op_o    = head_q.op;
  assign lane_mask_o = head_q.mask;
  assign sel_rro_o   = head_q.sel;

`ifdef SFU_IN_PERF_EN
  logic [31:0] rro_cnt_q, src_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rro_cnt_q <= '0;
      src_cnt_q <= '0;
    end else if (deliver) begin
      if (head_q.sel) rro_cnt_q <= rro_cnt_q + 32'd1;
      else            src_cnt_q <= src_cnt_q + 32'd1;
    end
  end

  assign rro_cnt_o = rro_cnt_q;
  assign src_cnt_o = src_cnt_q;
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_sfu_input_stage.sv
// Scoreboard bench for sfu_input_stage: directed beats, backpressure, flush, reset.
// Build with SFU_IN_PERF_EN defined to also exercise the beat counters.
module tb_sfu_input_stage;

  logic         clk = 1'b0;
  logic         rst_i, flush_i, in_valid_i, out_ready_i;
  logic         in_ready_o, out_valid_o, sel_rro_o;
  logic [2:0]   selop_i, sfu_op_o;
  logic [3:0]   lane_mask_i, lane_mask_o;
  logic [127:0] rro_input_i, src_i, sfu_input_o;
`ifdef SFU_IN_PERF_EN
  logic [31:0]  rro_cnt_o, src_cnt_o;
`endif

  always #5 clk = ~clk;

  sfu_input_stage dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .selop_i     (selop_i),
    .lane_mask_i (lane_mask_i),
    .rro_input_i (rro_input_i),
    .src_i       (src_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sfu_input_o (sfu_input_o),
    .sfu_op_o    (sfu_op_o),
    .lane_mask_o (lane_mask_o),
`ifdef SFU_IN_PERF_EN
    .rro_cnt_o   (rro_cnt_o),
    .src_cnt_o   (src_cnt_o),
`endif
    .sel_rro_o   (sel_rro_o)
  );

  typedef struct {
    logic [127:0] d;
    logic [2:0]   op;
    logic [3:0]   m;
    logic         s;
  } exp_t;

  exp_t sbq[$];
  int   nchk  = 0;
  int   nfail = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(logic [31:0] b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = b + i;
    return r;
  endfunction

  // Monitor: every delivered beat must match the oldest accepted beat.
  always @(negedge clk) begin
    if (out_valid_o && out_ready_i) begin
      if (sbq.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_beat: got %h expected none", sfu_input_o);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("beat_data", sfu_input_o, e.d);
        check("beat_op", 128'(sfu_op_o), 128'(e.op));
        check("beat_mask", 128'(lane_mask_o), 128'(e.m));
        check("beat_sel", 128'(sel_rro_o), 128'(e.s));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] m,
                      input logic [127:0] rro, input logic [127:0] src,
                      input logic [127:0] exp, input logic s,
                      input logic acc);
    exp_t e;
    selop_i     = op;
    lane_mask_i = m;
    rro_input_i = rro;
    src_i       = src;
    in_valid_i  = 1'b1;
    @(negedge clk);
    check("in_ready_at_offer", 128'(in_ready_o), 128'(acc));
    if (in_ready_o) begin
      e.d = exp; e.op = op; e.m = m; e.s = s;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sbq.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("drain_done", 128'(sbq.size()), 128'd0);
  endtask

  task automatic do_flush(input logic [2:0] op);
    selop_i     = op;
    lane_mask_i = 4'hF;
    rro_input_i = mk(32'hDEAD0000);
    src_i       = mk(32'hBEEF0000);
    in_valid_i  = 1'b1;
    flush_i     = 1'b1;
    @(negedge clk);
    sbq.delete();
    @(posedge clk); #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 128'(out_valid_o), 128'd0);
    check("flush_in_ready", 128'(in_ready_o), 128'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    selop_i = '0; lane_mask_i = '0; rro_input_i = '0; src_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid_o), 128'd0);
    check("rst_in_ready", 128'(in_ready_o), 128'd1);
    check("rst_data", sfu_input_o, 128'd0);
    @(posedge clk); #1;

    // Select, select-src, masking, back-to-back with the head draining
    out_ready_i = 1'b1;
    send(3'b001, 4'hF, mk(32'hA0000000), mk(32'h5), mk(32'hA0000000), 1'b1, 1'b1);
    check("latency_valid", 128'(out_valid_o), 128'd1);
    send(3'b010, 4'hF, mk(32'hA0000000), mk(32'h5), mk(32'h5), 1'b0, 1'b1);
    send(3'b100, 4'b0101, mk(32'hA0000000), mk(32'h5),
         {32'h0, 32'hA0000002, 32'h0, 32'hA0000000}, 1'b1, 1'b1);
    drain();
    @(negedge clk);
    check("idle_out_valid", 128'(out_valid_o), 128'd0);
    @(posedge clk); #1;

    // Backpressure: A to head, B to skid, C refused
    out_ready_i = 1'b0;
    send(3'b000, 4'hF, mk(32'h1100), mk(32'h2200), mk(32'h1100), 1'b1, 1'b1);
    send(3'b011, 4'b1010, mk(32'h3300), mk(32'h4400),
         {32'h4403, 32'h0, 32'h4401, 32'h0}, 1'b0, 1'b1);
    send(3'b001, 4'hF, mk(32'h5500), mk(32'h6600), mk(32'h5500), 1'b1, 1'b0);
    @(negedge clk);
    check("stall_data0", sfu_input_o, mk(32'h1100));
    repeat (2) @(negedge clk);
    check("stall_data1", sfu_input_o, mk(32'h1100));
    check("stall_in_ready", 128'(in_ready_o), 128'd0);
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    check("ready_after_a", 128'(in_ready_o), 128'd1);
    drain();

    // Flush with both entries full, then with one entry and a visible offer
    out_ready_i = 1'b0;
    send(3'b001, 4'hF, mk(32'h7700), mk(32'h8800), mk(32'h7700), 1'b1, 1'b1);
    send(3'b010, 4'hF, mk(32'h7700), mk(32'h8800), mk(32'h8800), 1'b0, 1'b1);
    do_flush(3'b001);
    send(3'b100, 4'hF, mk(32'h9900), mk(32'hAA00), mk(32'h9900), 1'b1, 1'b1);
    do_flush(3'b010);
    out_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_flush_idle", 128'(out_valid_o), 128'd0);
    send(3'b110, 4'b0011, mk(32'hC000), mk(32'hD000),
         {32'h0, 32'h0, 32'hD001, 32'hD000}, 1'b0, 1'b1);
    drain();

    // Reset mid-stream
    out_ready_i = 1'b0;
    send(3'b001, 4'hF, mk(32'hE000), mk(32'hF000), mk(32'hE000), 1'b1, 1'b1);
    send(3'b001, 4'hF, mk(32'hE100), mk(32'hF100), mk(32'hE100), 1'b1, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    sbq.delete();
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", 128'(out_valid_o), 128'd0);
    check("rst2_in_ready", 128'(in_ready_o), 128'd1);
    check("rst2_data", sfu_input_o, 128'd0);
    @(posedge clk); #1;

`ifdef SFU_IN_PERF_EN
    check("perf_rro_rst", 128'(rro_cnt_o), 128'd0);
    check("perf_src_rst", 128'(src_cnt_o), 128'd0);
    out_ready_i = 1'b1;
    send(3'b000, 4'hF, mk(32'h100), mk(32'h200), mk(32'h100), 1'b1, 1'b1);
    send(3'b010, 4'hF, mk(32'h100), mk(32'h200), mk(32'h200), 1'b0, 1'b1);
    send(3'b100, 4'hF, mk(32'h100), mk(32'h200), mk(32'h100), 1'b1, 1'b1);
    drain();
    @(posedge clk); #1;
    check("perf_rro", 128'(rro_cnt_o), 128'd2);
    check("perf_src", 128'(src_cnt_o), 128'd1);
    out_ready_i = 1'b0;
    send(3'b000, 4'hF, mk(32'h300), mk(32'h400), mk(32'h300), 1'b1, 1'b1);
    do_flush(3'b000);
    check("perf_rro_flush", 128'(rro_cnt_o), 128'd2);
    check("perf_src_flush", 128'(src_cnt_o), 128'd1);
`endif

    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("final_queue", 128'(sbq.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

endmodule
